uart_rx_frame: RTL and testbench

Parametrised UART receiver for the serial link path, the next generation of the fixed 8-bit, 2x-baud receiver FSM. It oversamples `rx` from the system clock using a programmable baud divider. It supports 5–9 data bits, optional even/odd parity and one or two stop bits. It delivers each received word on a valid/ready port with parity, framing and overrun status, and feeds the receive FIFO / register bank.

---
 rtl/uart_rx_frame.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with programmable baud divider.
//
// Frame format: 5..DATA_BITS data bits sent LSB first, an optional even/odd parity bit, and
// one or two stop bits. Each received word is presented on a valid/ready port together with
// its parity, framing and overrun status.
//
// Build option: define UART_RX_MAJORITY_EN to take each bit value as the 2-of-3 vote of the
// samples at sc = OVS/2-2, OVS/2-1 and OVS/2. The vote needs the third sample, so bit
// decisions are made one tick later, at sc = OVS/2. Bit boundaries are the same in both
// builds. Without the macro a single sample at sc = OVS/2-1 is used.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   baud_div_i     sample tick every baud_div_i+1 clocks
//   data_len_i     data bits per frame, 5..DATA_BITS; other values clamp to DATA_BITS
//   parity_en_i    parity bit present
//   parity_odd_i   1 = odd parity, 0 = even parity
//   stop2_i        two stop bits
//   rx_i           serial line, asynchronous, idle high
//   rx_data_o      received word, LSB-aligned, unused MSBs 0
//   rx_valid_o     word available
//   rx_ready_i     consumer accepts word
//   parity_err_o   parity mismatch for the word on rx_data_o
//   frame_err_o    a stop bit sampled 0 for the word on rx_data_o
//   overrun_o      a frame was lost while rx_valid_o was high
//   busy_o         receiver not idle
module uart_rx_frame #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned OVS       = 16,
   parameter int unsigned DIV_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DIV_W-1:0]     baud_div_i,
   input  logic [3:0]           data_len_i,
   input  logic                 parity_en_i,
   input  logic                 parity_odd_i,
   input  logic                 stop2_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int unsigned    ScW      = $clog2(OVS);
   localparam logic [ScW-1:0] ScSample = ScW'(OVS / 2 - 1);
   localparam logic [ScW-1:0] ScEnd    = ScW'(OVS - 1);
   localparam logic [3:0]     MaxLen   = 4'(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [ScW-1:0] ScVote0  = ScW'(OVS / 2 - 2);
   localparam logic [ScW-1:0] ScDecide = ScW'(OVS / 2);
`else
   localparam logic [ScW-1:0] ScDecide = ScSample;
`endif

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop1, StStop2, StBreak
   } state_e;

   // ---------------------------------------------------------------- synchroniser
   logic rx_meta_q, rx_s_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------- free-running tick
   logic [DIV_W-1:0] tc_q;
   logic             tick;

   // >= so a divider lowered while the counter is above it still wraps at once
   assign tick = (tc_q >= baud_div_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tc_q <= '0;
      else         tc_q <= tick ? '0 : tc_q + DIV_W'(1);
   end

   // ---------------------------------------------------------------- bit sampling
   state_e         state_q;
   logic [ScW-1:0] sc_q;
   logic           decide, bit_end, bit_val;

   assign decide  = tick && (sc_q == ScDecide);
   assign bit_end = tick && (sc_q == ScEnd);

`ifdef UART_RX_MAJORITY_EN
   logic vote0_q, vote1_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vote0_q <= 1'b1;
         vote1_q <= 1'b1;
      end else begin
         if (tick && sc_q == ScVote0)  vote0_q <= rx_s_q;
         if (tick && sc_q == ScSample) vote1_q <= rx_s_q;
      end
   end

   assign bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
   assign bit_val = rx_s_q;
`endif

   logic [3:0] len_eff;
   assign len_eff = (data_len_i >= 4'd5 && data_len_i <= MaxLen) ? data_len_i : MaxLen;

   // ---------------------------------------------------------------- frame FSM
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q, perr_q, ferr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         sc_q      <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         if (tick && state_q != StIdle) sc_q <= (sc_q == ScEnd) ? '0 : sc_q + ScW'(1);
         unique case (state_q)
            StIdle: begin
               if (!rx_s_q) begin
                  state_q   <= StStart;
                  sc_q      <= '0;
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  par_q     <= 1'b0;
                  perr_q    <= 1'b0;
                  ferr_q    <= 1'b0;
               end
            end
            StStart: begin
               if (decide && bit_val) state_q <= StIdle;  // false start
               else if (bit_end)      state_q <= StData;
            end
            StData: begin
               if (decide) begin
                  for (int unsigned i = 0; i < DATA_BITS; i++) begin
                     if (bit_cnt_q == 4'(i)) shift_q[i] <= bit_val;
                  end
                  par_q <= par_q ^ bit_val;
               end
               if (bit_end) begin
                  if (bit_cnt_q == len_eff - 4'd1) begin
                     bit_cnt_q <= '0;
                     state_q   <= parity_en_i ? StParity : StStop1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end
            end
            StParity: begin
               if (decide)  perr_q  <= ((par_q ^ bit_val) != parity_odd_i);
               if (bit_end) state_q <= StStop1;
            end
            StStop1: begin
               if (decide) begin
                  ferr_q <= ~bit_val;
                  if (!stop2_i) state_q <= bit_val ? StIdle : StBreak;
               end else if (bit_end && stop2_i) begin
                  state_q <= StStop2;
               end
            end
            StStop2: begin
               if (decide) state_q <= bit_val ? StIdle : StBreak;
            end
            StBreak: begin
               if (rx_s_q) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------- output holding register
   logic frame_done, ferr_final, xfer;

   // Frames complete at the sample point of the last stop bit.
   assign frame_done = decide && ((state_q == StStop1 && !stop2_i) || state_q == StStop2);
   assign ferr_final = ferr_q | ~bit_val;

   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q;

   assign xfer = rx_valid_q && rx_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else if (frame_done && (!rx_valid_q || rx_ready_i)) begin
         // Empty slot, or the held word leaves on this edge: take the new frame.
         rx_data_q    <= shift_q;
         parity_err_q <= perr_q;
         frame_err_q  <= ferr_final;
         rx_valid_q   <= 1'b1;
         overrun_q    <= 1'b0;
      end else if (frame_done) begin
         overrun_q <= 1'b1;
      end else if (xfer) begin
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end
   end

   assign rx_data_o    = rx_data_q;
   assign rx_valid_o   = rx_valid_q;
   assign parity_err_o = parity_err_q;
   assign frame_err_o  = frame_err_q;
   assign overrun_o    = overrun_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame (DATA_BITS=8, OVS=16).
module tb_uart_rx_frame;

   localparam int Ovs = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [15:0] baud_div = 16'd0;
   logic [3:0]  data_len = 4'd8;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop2 = 1'b0;
   logic        rx = 1'b1;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

   always #5 clk_i = ~clk_i;

   uart_rx_frame #(
      .DATA_BITS (8),
      .OVS       (Ovs),
      .DIV_W     (16)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .baud_div_i   (baud_div),
      .data_len_i   (data_len),
      .parity_en_i  (parity_en),
      .parity_odd_i (parity_odd),
      .stop2_i      (stop2),
      .rx_i         (rx),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (rx_ready),
      .parity_err_o (parity_err_o),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o)
   );

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef UART_RX_MAJORITY_EN
   localparam bit Majority = 1'b1;
`else
   localparam bit Majority = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   function automatic int eff_len(input logic [3:0] dl);
      return (dl >= 4'd5 && dl <= 4'd8) ? int'(dl) : 8;
   endfunction

   // What the receiver must report for a frame, from the line contents alone.
   function automatic exp_t model(input logic [7:0] data, input int len, input bit pen,
                                  input bit podd, input bit par_bit, input bit stop_bit,
                                  input int glitch_bit);
      exp_t e;
      e.data = 8'h00;
      for (int i = 0; i < len; i++) begin
         e.data[i] = data[i] & ~((i == glitch_bit) && !Majority);
      end
      e.perr = pen && (((^e.data) ^ par_bit) != podd);
      e.ferr = !stop_bit;
      return e;
   endfunction

   task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit stop_bit,
                             input int extra_low, input int glitch_bit, input bit drop);
      int         cpb;
      int         len;
      logic [7:0] mask;
      logic       p;
      exp_t       e;
      cpb  = (int'(baud_div) + 1) * Ovs;
      len  = eff_len(data_len);
      mask = 8'((1 << len) - 1);
      p    = (^(data & mask)) ^ parity_odd ^ flip_par;
      e    = model(data, len, parity_en, parity_odd, p, stop_bit, glitch_bit);
      if (!drop) exp_q.push_back(e);
      rx = 1'b0;
      wait_clk(cpb);
      for (int i = 0; i < len; i++) begin
         rx = data[i];
         if (i == glitch_bit) begin
            wait_clk(8);
            rx = 1'b0;
            wait_clk(1);
            rx = data[i];
            wait_clk(cpb - 9);
         end else begin
            wait_clk(cpb);
         end
      end
      if (parity_en) begin
         rx = p;
         wait_clk(cpb);
      end
      rx = stop_bit;
      wait_clk(cpb);
      if (stop2) begin
         rx = 1'b1;
         wait_clk(cpb);
      end
      if (extra_low > 0) begin
         rx = 1'b0;
         wait_clk(extra_low);
      end
      rx = 1'b1;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (rx_valid_o !== 1'b1 && n < budget) begin
         wait_clk(1);
         n++;
      end
      if (rx_valid_o !== 1'b1) check("valid_timeout", 32'(rx_valid_o), 32'd1);
   endtask

   task automatic consume();
      wait_valid(4000);
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
      check("valid_clear", 32'(rx_valid_o), 32'd0);
   endtask

   // Whenever a word is held it must match the oldest expected word.
   always @(negedge clk_i) begin
      if (rst_ni && rx_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(rx_valid_o), 32'd0);
         end else begin
            check("sb_data", 32'(rx_data_o), 32'(exp_q[0].data));
            check("sb_perr", 32'(parity_err_o), 32'(exp_q[0].perr));
            check("sb_ferr", 32'(frame_err_o), 32'(exp_q[0].ferr));
            if (rx_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      wait_clk(3);
      check("rst_data", 32'(rx_data_o), 32'd0);
      check("rst_valid", 32'(rx_valid_o), 32'd0);
      check("rst_perr", 32'(parity_err_o), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_ni = 1'b1;
      wait_clk(5);

      // 8N1 0x55
      send_frame(8'h55, 1'b0, 1'b1, 0, -1, 1'b0);
      check("t55_valid", 32'(rx_valid_o), 32'd1);
      check("t55_data", 32'(rx_data_o), 32'h55);
      check("t55_perr", 32'(parity_err_o), 32'd0);
      check("t55_ferr", 32'(frame_err_o), 32'd0);
      check("t55_overrun", 32'(overrun_o), 32'd0);
      consume();
      wait_clk(20);

      // 7E2, 0x41 with wrong parity bit
      data_len = 4'd7; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
      send_frame(8'h41, 1'b1, 1'b1, 0, -1, 1'b0);
      check("t41_data", 32'(rx_data_o), 32'h41);
      check("t41_perr", 32'(parity_err_o), 32'd1);
      check("t41_ferr", 32'(frame_err_o), 32'd0);
      consume();
      wait_clk(20);

      // 8N1 stop bit 0, line low 3 bit-times, then a clean frame
      data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 2 * Ovs, -1, 1'b0);
      check("tfe_ferr", 32'(frame_err_o), 32'd1);
      check("tfe_data", 32'(rx_data_o), 32'hA5);
      consume();
      wait_clk(40);
      check("tfe_no_more", 32'(rx_valid_o), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 0, -1, 1'b0);
      check("t3c_data", 32'(rx_data_o), 32'h3C);
      consume();
      wait_clk(20);

      // 5-tick false start
      rx = 1'b0;
      wait_clk(5);
      rx = 1'b1;
      wait_clk(1);
      check("fs_busy_hi", 32'(busy_o), 32'd1);
      wait_clk(30);
      check("fs_busy_lo", 32'(busy_o), 32'd0);
      check("fs_valid", 32'(rx_valid_o), 32'd0);

      // Overrun: two frames with ready low
      send_frame(8'h12, 1'b0, 1'b1, 0, -1, 1'b0);
      send_frame(8'h34, 1'b0, 1'b1, 0, -1, 1'b1);
      check("ovr_flag", 32'(overrun_o), 32'd1);
      check("ovr_data", 32'(rx_data_o), 32'h12);
      consume();
      check("ovr_clear", 32'(overrun_o), 32'd0);
      wait_clk(20);

      // One-clock low glitch at the centre of data bit 3 of 0xFF
      send_frame(8'hFF, 1'b0, 1'b1, 0, 3, 1'b0);
      check("glitch_data", 32'(rx_data_o), Majority ? 32'hFF : 32'hF7);
      consume();
      wait_clk(20);

      // Slower baud, 5O1
      baud_div = 16'd2; data_len = 4'd5; parity_en = 1'b1; parity_odd = 1'b1;
      send_frame(8'h13, 1'b0, 1'b1, 0, -1, 1'b0);
      check("t5o1_data", 32'(rx_data_o), 32'h13);
      check("t5o1_perr", 32'(parity_err_o), 32'd0);
      consume();
      wait_clk(20);

      // Out-of-range length clamps to 8 bits
      data_len = 4'd15; parity_en = 1'b0;
      send_frame(8'h9A, 1'b0, 1'b1, 0, -1, 1'b0);
      check("clamp_data", 32'(rx_data_o), 32'h9A);
      consume();
      wait_clk(20);

      // Reset mid-frame
      baud_div = 16'd0; data_len = 4'd8;
      rx = 1'b0;
      wait_clk(40);
      rst_ni = 1'b0;
      rx = 1'b1;
      wait_clk(1);
      check("mrst_busy", 32'(busy_o), 32'd0);
      check("mrst_valid", 32'(rx_valid_o), 32'd0);
      check("mrst_data", 32'(rx_data_o), 32'd0);
      wait_clk(2);
      rst_ni = 1'b1;
      wait_clk(300);
      check("mrst_no_word", 32'(rx_valid_o), 32'd0);

      // Receiver still works after the abort
      send_frame(8'hC3, 1'b0, 1'b1, 0, -1, 1'b0);
      consume();
      wait_clk(20);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
